// File: rtl/vermi_memory_pkg.sv
// Shared types and helpers for the Vermicel dual-port word RAM.
package vermi_memory_pkg;

   typedef logic [31:0] word_t;
   typedef logic [3:0]  strobe_t;
   typedef logic [31:0] byte_address_t;

   // Word index wraps modulo size_words, which must be a power of two.
   function automatic int unsigned word_index(byte_address_t address, int unsigned size_words);
      return 32'(address[31:2]) & (size_words - 1);
   endfunction

   function automatic word_t apply_strobe(word_t old_word, word_t wdata, strobe_t wstrobe);
      word_t res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (wstrobe[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/vermi_memory_port.sv
// Ready/rdata timing for one bus port: combinational lookahead or one-wait-state registered read.
module vermi_memory_port
   import vermi_memory_pkg::*;
#(
   parameter bit UseLookahead = 1'b1
) (
   input  logic  clk_i,
   input  logic  reset_i,
   input  logic  valid_i,
   input  word_t mem_rdata_i,
   output logic  ready_o,
   output word_t rdata_o,
   output logic  fire_o
);

   if (UseLookahead) begin : g_lookahead
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ reset_i;
      assign ready_o = valid_i;
      assign rdata_o = mem_rdata_i;
      assign fire_o  = valid_i;
   end else begin : g_registered
      logic  ready_q, ready_d;
      word_t rdata_q, rdata_d;

      always_comb begin
         ready_d = valid_i && !ready_q;
         rdata_d = rdata_q;
         if (ready_d) rdata_d = mem_rdata_i;
         // Reset drops any pending request; the requester waits again.
         if (reset_i) begin
            ready_d = 1'b0;
            rdata_d = '0;
         end
      end

      always_ff @(posedge clk_i) begin
         ready_q <= ready_d;
         rdata_q <= rdata_d;
      end

      assign ready_o = ready_q;
      assign rdata_o = rdata_q;
      assign fire_o  = valid_i && ready_q && !reset_i;
   end

endmodule

// File: rtl/vermi_memory.sv
// Dual-port word RAM: read-only ibus, read/write dbus, one shared array.
// Define VERMI_MEMORY_BOUNDS_CHECK_EN to return 0 and ignore writes beyond SIZE_WORDS.
module vermi_memory
   import vermi_memory_pkg::*;
#(
   parameter int unsigned SIZE_WORDS    = 65536,
   parameter string       INIT_FILENAME = "",
   parameter int unsigned USE_LOOKAHEAD = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ibus_valid,
   input  byte_address_t ibus_address,
   output logic          ibus_ready,
   output word_t         ibus_rdata,
   input  logic          dbus_valid,
   input  byte_address_t dbus_address,
   input  strobe_t       dbus_wstrobe,
   input  word_t         dbus_wdata,
   output logic          dbus_ready,
   output word_t         dbus_rdata,
   output logic          dbus_irq
);

   localparam int unsigned IdxW = $clog2(SIZE_WORDS);

   word_t            mem_q [SIZE_WORDS];
   logic [IdxW-1:0]  i_idx, d_idx;
   logic             i_in_range, d_in_range;
   word_t            i_mem_rdata, d_mem_rdata;
   word_t            mem_wdata;
   logic             mem_we;
   logic             d_fire;
   logic             i_fire_unused;
   logic             unused_addr;

   initial begin
      for (int i = 0; i < SIZE_WORDS; i++) mem_q[i] = '0;
   end

   assign i_idx = IdxW'(word_index(ibus_address, SIZE_WORDS));
   assign d_idx = IdxW'(word_index(dbus_address, SIZE_WORDS));

`ifdef VERMI_MEMORY_BOUNDS_CHECK_EN
   assign i_in_range = {2'b00, ibus_address[31:2]} < SIZE_WORDS;
   assign d_in_range = {2'b00, dbus_address[31:2]} < SIZE_WORDS;
`else
   assign i_in_range = 1'b1;
   assign d_in_range = 1'b1;
`endif

   assign unused_addr = ^{ibus_address, dbus_address};

   assign i_mem_rdata = i_in_range ? mem_q[i_idx] : '0;
   assign d_mem_rdata = d_in_range ? mem_q[d_idx] : '0;

   vermi_memory_port #(
      .UseLookahead (USE_LOOKAHEAD != 0)
   ) u_ibus_port (
      .clk_i       (clk),
      .reset_i     (reset),
      .valid_i     (ibus_valid),
      .mem_rdata_i (i_mem_rdata),
      .ready_o     (ibus_ready),
      .rdata_o     (ibus_rdata),
      .fire_o      (i_fire_unused)
   );

   vermi_memory_port #(
      .UseLookahead (USE_LOOKAHEAD != 0)
   ) u_dbus_port (
      .clk_i       (clk),
      .reset_i     (reset),
      .valid_i     (dbus_valid),
      .mem_rdata_i (d_mem_rdata),
      .ready_o     (dbus_ready),
      .rdata_o     (dbus_rdata),
      .fire_o      (d_fire)
   );

   always_comb begin
      mem_we    = d_fire && (dbus_wstrobe != '0) && d_in_range;
      mem_wdata = apply_strobe(mem_q[d_idx], dbus_wdata, dbus_wstrobe);
   end

   // Nonblocking write: same-edge readers on either port see the old word.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[d_idx] <= mem_wdata;
   end

   assign dbus_irq = 1'b0;

endmodule

// File: tb/tb_vermi_memory.sv
// Self-checking bench: a lookahead and a registered instance driven in turn from one stimulus set.
module tb_vermi_memory;

   logic        clk = 1'b0;
   logic        reset;
   logic        mode;
   logic        ibus_valid;
   logic [31:0] ibus_address;
   logic        dbus_valid;
   logic [31:0] dbus_address;
   logic [3:0]  dbus_wstrobe;
   logic [31:0] dbus_wdata;

   logic        la_i_ready, la_d_ready, la_irq, rg_i_ready, rg_d_ready, rg_irq;
   logic [31:0] la_i_rdata, la_d_rdata, rg_i_rdata, rg_d_rdata;
   logic        cur_i_ready, cur_d_ready;
   logic [31:0] cur_i_rdata, cur_d_rdata;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic        is_i;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs [11];
   logic [31:0] sb_q [$];

   always #5 clk = ~clk;

   vermi_memory #(
      .SIZE_WORDS    (65536),
      .INIT_FILENAME (""),
      .USE_LOOKAHEAD (1)
   ) u_la (
      .clk          (clk),
      .reset        (reset),
      .ibus_valid   (ibus_valid && !mode),
      .ibus_address (ibus_address),
      .ibus_ready   (la_i_ready),
      .ibus_rdata   (la_i_rdata),
      .dbus_valid   (dbus_valid && !mode),
      .dbus_address (dbus_address),
      .dbus_wstrobe (dbus_wstrobe),
      .dbus_wdata   (dbus_wdata),
      .dbus_ready   (la_d_ready),
      .dbus_rdata   (la_d_rdata),
      .dbus_irq     (la_irq)
   );

   vermi_memory #(
      .SIZE_WORDS    (65536),
      .INIT_FILENAME (""),
      .USE_LOOKAHEAD (0)
   ) u_rg (
      .clk          (clk),
      .reset        (reset),
      .ibus_valid   (ibus_valid && mode),
      .ibus_address (ibus_address),
      .ibus_ready   (rg_i_ready),
      .ibus_rdata   (rg_i_rdata),
      .dbus_valid   (dbus_valid && mode),
      .dbus_address (dbus_address),
      .dbus_wstrobe (dbus_wstrobe),
      .dbus_wdata   (dbus_wdata),
      .dbus_ready   (rg_d_ready),
      .dbus_rdata   (rg_d_rdata),
      .dbus_irq     (rg_irq)
   );

   always_comb begin
      cur_i_ready = mode ? rg_i_ready : la_i_ready;
      cur_d_ready = mode ? rg_d_ready : la_d_ready;
      cur_i_rdata = mode ? rg_i_rdata : la_i_rdata;
      cur_d_rdata = mode ? rg_d_rdata : la_d_rdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (mode %0d): got %08h expected %08h", name, mode, act, exp);
   endtask

   task automatic idle_inputs();
      ibus_valid   = 1'b0;
      dbus_valid   = 1'b0;
      dbus_wstrobe = 4'b0000;
   endtask

   // Drive one request, wait (bounded) for ready, compare latency and data.
   task automatic access(input vec_t v, input string name);
      int          n;
      logic        ok;
      logic [31:0] act;
      logic [31:0] exp;
      sb_q.push_back(v.exp);
      if (v.is_i) begin
         ibus_valid   = 1'b1;
         ibus_address = v.addr;
      end else begin
         dbus_valid   = 1'b1;
         dbus_address = v.addr;
         dbus_wstrobe = v.strb;
         dbus_wdata   = v.wdata;
      end
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 8) begin
         @(negedge clk);
         if (v.is_i ? cur_i_ready : cur_d_ready) ok = 1'b1;
         else n++;
      end
      check({name, "_latency"}, ok ? 32'(n) : 32'hffff_ffff, mode ? 32'd1 : 32'd0);
      act = v.is_i ? cur_i_rdata : cur_d_rdata;
      exp = sb_q.pop_front();
      if (ok) check({name, "_rdata"}, act, exp);
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic same_cycle_rw();
      int   n;
      vec_t v;
      ibus_valid   = 1'b1;
      ibus_address = 32'h200;
      dbus_valid   = 1'b1;
      dbus_address = 32'h200;
      dbus_wstrobe = 4'b1111;
      dbus_wdata   = 32'h1234_5678;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!cur_i_ready && n < 8);
      check("same_cycle_i_ready", 32'(cur_i_ready), 32'd1);
      check("same_cycle_d_ready", 32'(cur_d_ready), 32'd1);
      check("same_cycle_i_old", cur_i_rdata, 32'h0);
      @(posedge clk);
      #1;
      idle_inputs();
      v = '{1'b1, 32'h200, 4'b0000, 32'h0, 32'h1234_5678};
      access(v, "same_cycle_i_new");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mode         = 1'b0;
      reset        = 1'b1;
      ibus_address = '0;
      dbus_address = '0;
      dbus_wdata   = '0;
      idle_inputs();

      vecs[0]  = '{1'b0, 32'h0000_0000, 4'b1111, 32'h0000_0013, 32'h0000_0000};
      vecs[1]  = '{1'b1, 32'h0000_0000, 4'b0000, 32'h0,         32'h0000_0013};
      vecs[2]  = '{1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[3]  = '{1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 32'h0000_0100, 4'b0010, 32'h0000_AA00, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'hDEAD_AAEF};
      vecs[6]  = '{1'b1, 32'h0000_0102, 4'b0000, 32'h0,         32'hDEAD_AAEF};
      vecs[7]  = '{1'b0, 32'h0000_0104, 4'b1001, 32'hA1B2_C3D4, 32'h0000_0000};
      vecs[8]  = '{1'b0, 32'h0000_0104, 4'b0000, 32'h0,         32'hA100_00D4};
`ifdef VERMI_MEMORY_BOUNDS_CHECK_EN
      vecs[9]  = '{1'b1, 32'h0004_0000, 4'b0000, 32'h0,         32'h0000_0000};
      vecs[10] = '{1'b0, 32'h0004_0103, 4'b0000, 32'h0,         32'h0000_0000};
`else
      vecs[9]  = '{1'b1, 32'h0004_0000, 4'b0000, 32'h0,         32'h0000_0013};
      vecs[10] = '{1'b0, 32'h0004_0103, 4'b0000, 32'h0,         32'hDEAD_AAEF};
`endif

      repeat (2) @(posedge clk);
      #1;
      check("reset_rg_i_ready", 32'(rg_i_ready), 32'd0);
      check("reset_rg_d_ready", 32'(rg_d_ready), 32'd0);
      check("reset_rg_i_rdata", rg_i_rdata, 32'h0);
      check("reset_rg_d_rdata", rg_d_rdata, 32'h0);
      check("irq_la", 32'(la_irq), 32'd0);
      check("irq_rg", 32'(rg_irq), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int m = 0; m < 2; m++) begin
         mode = m[0];
         for (int i = 0; i < 11; i++) access(vecs[i], $sformatf("vec%0d", i));
         same_cycle_rw();
      end

      // Registered mode: reset during the wait drops a pending byte write to 0x100.
      mode         = 1'b1;
      dbus_valid   = 1'b1;
      dbus_address = 32'h100;
      dbus_wstrobe = 4'b0001;
      dbus_wdata   = 32'h0000_0077;
      @(posedge clk);
      #1;
      check("rst_wait_ready_pre", 32'(rg_d_ready), 32'd1);
      check("rst_wait_rdata_pre", rg_d_rdata, 32'hDEAD_AAEF);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_wait_d_ready", 32'(rg_d_ready), 32'd0);
      check("rst_wait_d_rdata", rg_d_rdata, 32'h0);
      check("rst_wait_i_rdata", rg_i_rdata, 32'h0);
      reset = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1;
      access('{1'b0, 32'h100, 4'b0000, 32'h0, 32'hDEAD_AAEF}, "rst_mem_intact");

      // Registered mode: valid withdrawn after one cycle must not write.
      dbus_valid   = 1'b1;
      dbus_address = 32'h400;
      dbus_wstrobe = 4'b1111;
      dbus_wdata   = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      dbus_valid = 1'b0;
      @(posedge clk);
      #1;
      check("abort_ready_low", 32'(rg_d_ready), 32'd0);
      access('{1'b0, 32'h400, 4'b0000, 32'h0, 32'h0}, "abort_no_write");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
